// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables and state byte helpers.
// INV_SBOX is only referenced when SUBBYTES_INV_EN is defined.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} sb_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 is the most significant byte of the state.
    function automatic logic [AES_BYTE_W-1:0] state_byte(input logic [AES_STATE_W-1:0] s,
                                                          input int unsigned i);
        return s[AES_STATE_W-1-AES_BYTE_W*i -: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lane; with SUBBYTES_INV_EN an inv input selects the
// inverse table. Also intended for reuse by key expansion.
module aes_sbox
    import aes_pkg::*;
(
`ifdef SUBBYTES_INV_EN
    input  logic                  inv,
`endif
    input  logic [AES_BYTE_W-1:0] din,
    output logic [AES_BYTE_W-1:0] dout
);

`ifdef SUBBYTES_INV_EN
    assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
    assign dout = SBOX[din];
`endif

endmodule

// File: rtl/subbytes_iter.sv
// Iterative SubBytes: LANES S-box lanes walk the 16 state bytes in place, result
// held with valid/ready. SUBBYTES_INV_EN adds an inv port for InvSubBytes.
module subbytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef SUBBYTES_INV_EN
    input  logic                   inv,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int unsigned NCYC = 16 / LANES;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  lane_out [LANES];
    int unsigned            base;
    logic                   last;

`ifdef SUBBYTES_INV_EN
    logic inv_q, inv_d;
`endif

    assign last = (cnt_q == CW'(NCYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StBusy;
            StBusy:  if (last)      state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    assign out_state = work_q;

    // Lane l of this cycle handles state byte cnt*LANES + l.
    always_comb begin
        base = 32'(cnt_q) * LANES;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = state_byte(work_q, base + l);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox u_sbox (
`ifdef SUBBYTES_INV_EN
            .inv  (inv_q),
`endif
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_comb begin
        cnt_d  = cnt_q;
        work_d = work_q;
`ifdef SUBBYTES_INV_EN
        inv_d  = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d = in_state;
                    cnt_d  = '0;
`ifdef SUBBYTES_INV_EN
                    inv_d  = inv;
`endif
                end
            end
            StBusy: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_d[AES_STATE_W-1-AES_BYTE_W*(base+l) -: AES_BYTE_W] = lane_out[l];
                end
                cnt_d = last ? '0 : cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            work_q <= work_d;
        end
    end

`ifdef SUBBYTES_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

endmodule

// File: tb/tb_subbytes_iter.sv
// Bench for subbytes_iter: five instances (LANES 1,2,4,8,16) against a GF(2^8)
// derived SubBytes model. Inverse checks run when SUBBYTES_INV_EN is defined.
module tb_subbytes_iter;

    localparam int NDUT = 5;
    localparam int MAIN = 2;  // LANES = 4
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NDUT-1:0]   in_valid = '0;
    logic [NDUT-1:0]   out_ready = '0;
    logic [NDUT-1:0]   in_ready;
    logic [NDUT-1:0]   out_valid;
    logic [127:0]      in_state = '0;
    logic [127:0]      out_state [NDUT];
`ifdef SUBBYTES_INV_EN
    logic [NDUT-1:0]   inv = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        subbytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef SUBBYTES_INV_EN
            .inv       (inv[g]),
`endif
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse as a^254, then the AES affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = s[127-8*i -: 8];
            r[127-8*i -: 8] = iv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_one(input int g, input logic [127:0] s, input logic iv);
        check($sformatf("in_ready idle [%0d]", g), 128'(in_ready[g]), 128'd1);
        in_valid[g] = 1'b1;
        in_state    = s;
`ifdef SUBBYTES_INV_EN
        inv[g]      = iv;
`else
        if (iv) $display("inverse requested without SUBBYTES_INV_EN");
`endif
        tick();
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g, output int lat);
        lat = 0;
        while (!out_valid[g] && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int g);
        out_ready[g] = 1'b1;
        tick();
        out_ready[g] = 1'b0;
        check($sformatf("out_valid drop [%0d]", g), 128'(out_valid[g]), 128'd0);
    endtask

    task automatic run_one(input int g, input string tag, input logic [127:0] s,
                           input logic iv, input logic [127:0] exp);
        int lat;
        accept_one(g, s, iv);
        wait_valid(g, lat);
        check($sformatf("%s latency [%0d]", tag, g), 128'(lat), 128'(16 >> g));
        check($sformatf("%s data [%0d]", tag, g), out_state[g], exp);
        drain(g);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] snap;
        logic [127:0] exp_q [$];
        logic [127:0] nxt;
        logic         iv;
        int           lat, cyc, last_acc, n_acc;
        bit           change;

        for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_calc(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        #1;
        check("reset out_valid", 128'(out_valid[MAIN]), 128'd0);
        check("reset out_state", out_state[MAIN], 128'd0);
        check("reset in_ready", 128'(in_ready[MAIN]), 128'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_one(MAIN, "zero", '0, 1'b0, {16{8'h63}});
        for (int g = 0; g < NDUT; g++) run_one(g, "fips", FIPS_IN, 1'b0, FIPS_OUT);

        // Backpressure in DONE; an in_valid pulse meanwhile must not be taken.
        snap = rand128();
        accept_one(MAIN, snap, 1'b0);
        wait_valid(MAIN, lat);
        check("bp latency", 128'(lat), 128'd4);
        check("bp data", out_state[MAIN], model(snap, 1'b0));
        snap = model(snap, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid[MAIN] = 1'b1;
                in_state       = rand128();
            end
            if (k == 5) in_valid[MAIN] = 1'b0;
            tick();
            check("bp out_valid", 128'(out_valid[MAIN]), 128'd1);
            check("bp out_state", out_state[MAIN], snap);
            check("bp in_ready", 128'(in_ready[MAIN]), 128'd0);
        end
        drain(MAIN);
        for (int k = 0; k < 6; k++) begin
            check("bp no capture in_ready", 128'(in_ready[MAIN]), 128'd1);
            check("bp no capture out_valid", 128'(out_valid[MAIN]), 128'd0);
            tick();
        end

        // Asynchronous reset two cycles into a transaction.
        accept_one(MAIN, rand128(), 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 128'(out_valid[MAIN]), 128'd0);
        check("mid reset out_state", out_state[MAIN], 128'd0);
        check("mid reset in_ready", 128'(in_ready[MAIN]), 128'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_one(MAIN, "after reset", {16{8'hff}}, 1'b0, {16{8'h16}});

`ifdef SUBBYTES_INV_EN
        run_one(MAIN, "inv 63", {16{8'h63}}, 1'b1, '0);
        run_one(MAIN, "inv fips", FIPS_OUT, 1'b1, FIPS_IN);
`endif

        // Streaming: in_valid and out_ready held high, 1000 random states.
        // Accept, 4 BUSY edges, DONE->IDLE edge, IDLE->accept edge: 6 cycles apart.
        out_ready[MAIN] = 1'b1;
        in_state        = rand128();
        iv              = 1'b0;
`ifdef SUBBYTES_INV_EN
        iv              = 1'($urandom_range(0, 1));
        inv[MAIN]       = iv;
`endif
        in_valid[MAIN]  = 1'b1;
        cyc = 0; last_acc = 0; n_acc = 0; change = 1'b0;
        while ((n_acc < 1000 || exp_q.size() != 0) && cyc < 7000) begin
            if (out_valid[MAIN]) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected output", 128'(out_valid[MAIN]), 128'd0);
                end else begin
                    nxt = exp_q.pop_front();
                    check("stream data", out_state[MAIN], nxt);
                end
            end
            if (in_ready[MAIN] && in_valid[MAIN]) begin
                exp_q.push_back(model(in_state, iv));
                if (n_acc > 0) check("stream interval", 128'(cyc - last_acc), 128'd6);
                last_acc = cyc;
                n_acc++;
                change   = 1'b1;
            end
            tick();
            cyc++;
            if (change) begin
                change = 1'b0;
                if (n_acc >= 1000) begin
                    in_valid[MAIN] = 1'b0;
                end else begin
                    in_state = rand128();
`ifdef SUBBYTES_INV_EN
                    iv        = 1'($urandom_range(0, 1));
                    inv[MAIN] = iv;
`endif
                end
            end
        end
        check("stream accepted", 128'(n_acc), 128'd1000);
        check("stream drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
